// File: rtl/alu_mdu.sv
// EX-stage execute unit: single-cycle integer ALU plus an iterative RV32M/RV64M
// multiply/divide engine behind one valid/ready handshake with a registered result.
module alu_mdu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  input  logic [3:0]      opcode_in,
  input  logic            m_ext_in,
  input  logic            flush_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out,
  output logic            busy_out
);

  localparam int unsigned CW = SHW + 1;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic accept;
  assign ready_out  = (state_q == StIdle) || ((state_q == StDone) && ready_in);
  assign accept     = valid_in && ready_out && !flush_in;
  assign valid_out  = (state_q == StDone);
  assign busy_out   = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign result_out = result_q;

  // Base ALU
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0]        alu_res;

  assign shamt   = op_2_in[SHW-1:0];
  // Kept in its own signed net so the arithmetic shift is not lost to unsigned context.
  assign sra_res = $signed(op_1_in) >>> shamt;

  always_comb begin
    alu_res = '0;
    unique case (opcode_in[2:0])
      3'b000:  alu_res = opcode_in[3] ? (op_1_in - op_2_in) : (op_1_in + op_2_in);
      3'b001:  alu_res = op_1_in << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_1_in) < $signed(op_2_in)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, op_1_in < op_2_in};
      3'b100:  alu_res = op_1_in ^ op_2_in;
      3'b101:  alu_res = opcode_in[3] ? sra_res : (op_1_in >> shamt);
      3'b110:  alu_res = op_1_in | op_2_in;
      3'b111:  alu_res = op_1_in & op_2_in;
      default: alu_res = '0;
    endcase
  end

  // M-op operand preparation: iterate on magnitudes, fix the sign at the end
  logic            a_sgn_op, b_sgn_op, a_neg, b_neg, b_zero, neg_init;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn_op = (opcode_in[2:0] == 3'b001) || (opcode_in[2:0] == 3'b010) ||
                    (opcode_in[2:0] == 3'b100) || (opcode_in[2:0] == 3'b110);
  assign b_sgn_op = (opcode_in[2:0] == 3'b001) || (opcode_in[2:0] == 3'b100) ||
                    (opcode_in[2:0] == 3'b110);
  assign a_neg    = a_sgn_op && op_1_in[XLEN-1];
  assign b_neg    = b_sgn_op && op_2_in[XLEN-1];
  assign a_mag    = a_neg ? -op_1_in : op_1_in;
  assign b_mag    = b_neg ? -op_2_in : op_2_in;
  assign b_zero   = (op_2_in == '0);
  // Divide by zero must leave the all-ones quotient un-negated; remainder follows dividend.
  assign neg_init = opcode_in[2] ? (opcode_in[1] ? a_neg : ((a_neg ^ b_neg) && !b_zero))
                                 : (a_neg ^ b_neg);

  // One shift-add step: acc = {partial product, remaining multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring step: acc = {partial remainder, dividend bits / quotient bits}
  logic [XLEN:0]     div_shift, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_ge ? (div_shift - {1'b0, opb_q}) : div_shift;
  assign div_next  = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};

  // Final sign correction and half/quotient/remainder select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dsel, dres, fix_res;
  assign prod = neg_q ? -acc_q : acc_q;
  assign dsel = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign dres = neg_q ? -dsel : dsel;

  always_comb begin
    fix_res = '0;
    if (f3_q[2]) begin
      fix_res = dres;
    end else if (f3_q[1:0] == 2'b00) begin
      fix_res = prod[XLEN-1:0];
    end else begin
      fix_res = prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;

    unique case (state_q)
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: begin
        if (ready_in) state_d = StIdle;
      end
      default: ;
    endcase

    if (accept) begin
      f3_d = opcode_in[2:0];
      if (!m_ext_in) begin
        result_d = alu_res;
        state_d  = StDone;
      end else begin
        neg_d = neg_init;
        cnt_d = CW'(XLEN);
        if (opcode_in[2]) begin
          acc_d   = {{XLEN{1'b0}}, a_mag};
          opb_d   = b_mag;
          state_d = StDiv;
        end else begin
          acc_d   = {{XLEN{1'b0}}, b_mag};
          opb_d   = a_mag;
          state_d = StMul;
        end
      end
    end

    // Flush wins over everything, including a FIX write in the same cycle.
    if (flush_in) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule
